// File: rtl/buffer_pkg.sv
// Shared types, defaults and helpers for the buffer arbiter and its occupancy tracker.
package buffer_pkg;

  localparam int DEF_BUF_DEPTH    = 64;
  localparam int DEF_STARVE_LIMIT = 4;

  // AHB access size encoding; the unused code 2'd3 behaves like a word.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_USB = 2'd1,
    GNT_AHB = 2'd2,
    FLUSH   = 2'd3
  } arb_state_e;

  // Which requester wins the arbitration decision taken in IDLE.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_TX   = 2'd1,
    SEL_RX   = 2'd2,
    SEL_AHB  = 2'd3
  } arb_sel_e;

  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/occupancy_counter.sv
// Byte occupancy tracker: adds on buffer writes, subtracts on reads, clamps to 0..BUF_DEPTH.
module occupancy_counter
  import buffer_pkg::*;
#(
  parameter int BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int CNT_W     = $clog2(DEF_BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic [2:0]       nbytes,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [2:0]       n);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(n);
    if (sum > (CNT_W+1)'(BUF_DEPTH)) return CNT_W'(BUF_DEPTH);
    return sum[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a,
                                               input logic [2:0]       n);
    if (a < CNT_W'(n)) return '0;
    return a - CNT_W'(n);
  endfunction

  // Next count: apply the access, then let a flush override it so a clear in a grant cycle ends at 0.
  always_comb begin
    count_d = count_q;
    if (inc)      count_d = sat_add(count_q, nbytes);
    else if (dec) count_d = sat_sub(count_q, nbytes);
    if (clear)    count_d = '0;
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/buffer_arbiter.sv
// Arbitrates shared data-buffer access between USB RX/TX and the AHB side,
// with occupancy-aware qualification and an AHB anti-starvation override.
module buffer_arbiter
  import buffer_pkg::*;
#(
  parameter int BUF_DEPTH    = DEF_BUF_DEPTH,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int OCC_W        = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             ahb_req,
  input  logic             ahb_wr,
  input  logic [1:0]       ahb_size,
  input  logic             usb_rx_req,
  input  logic             usb_tx_req,
  output logic             ahb_gnt,
  output logic             usb_rx_gnt,
  output logic             usb_tx_gnt,
  output logic             buf_we,
  output logic             buf_re,
  output logic [2:0]       buf_nbytes,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             ahb_stall
);

  localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  arb_state_e       state_q, state_d;
  arb_sel_e         sel;
  logic [STV_W-1:0] stv_q, stv_d;
  logic             starved;

  logic             ahb_gnt_q, ahb_gnt_d;
  logic             usb_rx_gnt_q, usb_rx_gnt_d;
  logic             usb_tx_gnt_q, usb_tx_gnt_d;
  logic             buf_we_q, buf_we_d;
  logic             buf_re_q, buf_re_d;
  logic [2:0]       buf_nbytes_q, buf_nbytes_d;

  logic [OCC_W-1:0] occ;
  logic [2:0]       ahb_n;
  logic             ahb_ok;
  logic             rx_ok;
  logic             tx_ok;

  // A request only qualifies when the buffer can take (or supply) all of its bytes.
  assign ahb_n  = size_to_bytes(ahb_size);
  assign ahb_ok = ahb_req &&
                  (ahb_wr ? (({1'b0, occ} + (OCC_W+1)'(ahb_n)) <= (OCC_W+1)'(BUF_DEPTH))
                          : (occ >= OCC_W'(ahb_n)));
  assign rx_ok  = usb_rx_req && (occ < OCC_W'(BUF_DEPTH));
  assign tx_ok  = usb_tx_req && (occ != '0);

  assign starved = (stv_q >= STV_W'(STARVE_LIMIT));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: decide only from IDLE, every grant or flush returns to IDLE, clear preempts all.
  always_comb begin
    sel     = SEL_NONE;
    state_d = IDLE;
    if (state_q == IDLE) begin
      if (starved && ahb_ok) sel = SEL_AHB;
      else if (tx_ok)        sel = SEL_TX;
      else if (rx_ok)        sel = SEL_RX;
      else if (ahb_ok)       sel = SEL_AHB;
      unique case (sel)
        SEL_TX, SEL_RX: state_d = GNT_USB;
        SEL_AHB:        state_d = GNT_AHB;
        default:        state_d = IDLE;
      endcase
    end
    if (clear) begin
      sel     = SEL_NONE;
      state_d = FLUSH;
    end
  end

  // Output decode: next values of the registered grants and strobes.
  always_comb begin
    ahb_gnt_d    = (sel == SEL_AHB);
    usb_tx_gnt_d = (sel == SEL_TX);
    usb_rx_gnt_d = (sel == SEL_RX);
    buf_we_d     = (sel == SEL_RX) || ((sel == SEL_AHB) && ahb_wr);
    buf_re_d     = (sel == SEL_TX) || ((sel == SEL_AHB) && !ahb_wr);
    unique case (sel)
      SEL_AHB:        buf_nbytes_d = ahb_n;
      SEL_TX, SEL_RX: buf_nbytes_d = 3'd1;
      default:        buf_nbytes_d = 3'd0;
    endcase
  end

  // Registered grants/strobes; they are high exactly during the GNT_* cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ahb_gnt_q    <= 1'b0;
      usb_rx_gnt_q <= 1'b0;
      usb_tx_gnt_q <= 1'b0;
      buf_we_q     <= 1'b0;
      buf_re_q     <= 1'b0;
      buf_nbytes_q <= 3'd0;
    end else begin
      ahb_gnt_q    <= ahb_gnt_d;
      usb_rx_gnt_q <= usb_rx_gnt_d;
      usb_tx_gnt_q <= usb_tx_gnt_d;
      buf_we_q     <= buf_we_d;
      buf_re_q     <= buf_re_d;
      buf_nbytes_q <= buf_nbytes_d;
    end
  end

  // Starvation count: consecutive cycles the AHB side has been stalled, saturating at the limit.
  always_comb begin
    stv_d = stv_q;
    if (clear || !ahb_req || ahb_gnt_q)    stv_d = '0;
    else if (stv_q < STV_W'(STARVE_LIMIT)) stv_d = stv_q + 1'b1;
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stv_q <= '0;
    else     stv_q <= stv_d;
  end

  occupancy_counter #(
    .BUF_DEPTH (BUF_DEPTH),
    .CNT_W     (OCC_W)
  ) u_occ (
    .clk    (clk),
    .rst    (rst),
    .inc    (buf_we_q),
    .dec    (buf_re_q),
    .nbytes (buf_nbytes_q),
    .clear  (clear),
    .count  (occ)
  );

  assign ahb_gnt          = ahb_gnt_q;
  assign usb_rx_gnt       = usb_rx_gnt_q;
  assign usb_tx_gnt       = usb_tx_gnt_q;
  assign buf_we           = buf_we_q;
  assign buf_re           = buf_re_q;
  assign buf_nbytes       = buf_nbytes_q;
  assign buffer_occupancy = occ;
  assign ahb_stall        = ahb_req && !ahb_gnt_q;

endmodule

// File: doc/buffer_arbiter.md
BUFFER_ARBITER -- requirements
Module: buffer_arbiter

Interface
REQ-001 Parameter BUF_DEPTH, default 64: data buffer capacity in bytes.
REQ-002 Parameter STARVE_LIMIT, default 4: maximum cycles an AHB request waits behind USB traffic.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 clear  in  1  flush request from the protocol controller; single-cycle pulse.
REQ-006 ahb_req  in  1  AHB-side buffer access request; held until granted.
REQ-007 ahb_wr  in  1  1 = store TX data into buffer, 0 = get RX data from buffer.
REQ-008 ahb_size  in  2  access size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is reserved and treated as 4 bytes.
REQ-009 usb_rx_req  in  1  USB RX requests to store one byte; held until granted.
REQ-010 usb_tx_req  in  1  USB TX requests to get one byte; held until granted.
REQ-011 ahb_gnt, usb_rx_gnt, usb_tx_gnt  out  1 each  one-cycle grant pulses.
REQ-012 buf_we  out  1  buffer write strobe, coincident with the grant.
REQ-013 buf_re  out  1  buffer read strobe, coincident with the grant.
REQ-014 buf_nbytes  out  3  byte count of the granted access: 1, 2 or 4.
REQ-015 buffer_occupancy  out  7  bytes currently held, range 0..BUF_DEPTH.
REQ-016 ahb_stall  out  1  high while ahb_req is pending and not granted.

Function
REQ-017 The arbiter SHALL be a state machine with states IDLE, GNT_USB, GNT_AHB and FLUSH; all grants and strobes SHALL be registered, giving 1-cycle latency from a qualifying request to its grant.
REQ-018 Arbitration priority SHALL be, highest first: clear, usb_tx_req, usb_rx_req, ahb_req.
REQ-019 Exception to REQ-018: when ahb_stall has been high for STARVE_LIMIT consecutive cycles and the AHB request qualifies, the AHB request SHALL win the next grant.
REQ-020 A request qualifies only if the buffer can satisfy it.
- Writes qualify only if occupancy + n <= BUF_DEPTH.
- Reads qualify only if occupancy >= n.
- A non-qualifying request SHALL stay pending, ungranted, with no error raised.
REQ-021 At most one grant SHALL be asserted per cycle.
REQ-022 After each grant the FSM SHALL return to IDLE, so back-to-back grants to the same requester occur at most every other cycle.
REQ-023 Occupancy SHALL update in the cycle after the grant: +n on a write, -n on a read.
REQ-024 Occupancy arithmetic SHALL never wrap below 0 or above BUF_DEPTH.
REQ-025 On clear the FSM SHALL enter FLUSH for one cycle.
- Occupancy SHALL be 0 the cycle after clear.
- No grant SHALL be issued in that cycle.
- Pending requests SHALL remain pending and be re-arbitrated from IDLE.
REQ-026 A clear arriving in the same cycle as a grant SHALL still apply the granted access first; occupancy ends at 0.
REQ-027 ahb_stall SHALL be combinational: ahb_req AND NOT ahb_gnt.
REQ-028 The starvation counter SHALL reset to 0 on an AHB grant, on clear, and whenever ahb_req is low.

Reset
REQ-029 While rst is high: state = IDLE; all grants, buf_we, buf_re = 0; buf_nbytes = 0; buffer_occupancy = 0; starvation counter = 0.
REQ-030 Reset asserted mid-access SHALL drop the access; no strobe SHALL be issued after reset release until a new request arrives.

Structure
REQ-031 Package buffer_pkg SHALL hold:
- BUF_DEPTH and STARVE_LIMIT defaults;
- the size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
- the arbiter state enum;
- the size-to-byte-count function.
REQ-032 Occupancy tracking SHALL be a separate sub-module, occupancy_counter, with inputs inc, dec, nbytes and clear, and output count.

Verification
REQ-033 From reset, usb_rx_req held for 3 grants -> usb_rx_gnt pulses on cycles 1, 3 and 5; buffer_occupancy = 3.
REQ-034 Occupancy 62, AHB word write requested -> no grant, ahb_stall stays high; after 2 usb_tx reads (occupancy 60) -> ahb_gnt with buf_nbytes = 4, occupancy 64.
REQ-035 usb_rx_req and ahb_req (read, 1 byte) held continuously, occupancy 10 -> ahb_gnt no later than STARVE_LIMIT + 1 = 5 cycles after ahb_stall rises.
REQ-036 usb_tx_req and usb_rx_req asserted together -> usb_tx_gnt first; never two grants in one cycle.
REQ-037 Occupancy 20, clear pulsed in the same cycle as an AHB 2-byte write grant -> occupancy 0 the next cycle; no grant during FLUSH.
REQ-038 rst asserted asynchronously mid-GNT_AHB -> all outputs 0 immediately; occupancy 0; no strobe after rst release.
